// File: rtl/cmd_loader.sv
// cmd_loader
//   Parses a TRS-80 /CMD image streamed from the HPS download channel and
//   turns its load blocks into sequenced byte writes into system RAM. When a
//   clean download finishes after a transfer block, it requests a jump to
//   the program's transfer address.
//
// Ports
//   clk_sys, reset_n      system clock, synchronous active-low reset
//   ioctl_download        download in progress (hps_io)
//   ioctl_index [7:0]     file type index; CMD_INDEX selects this loader
//   ioctl_wr, ioctl_dout  one-cycle byte strobe and byte
//   ioctl_wait            stall request to hps_io while a RAM write is pending
//   mem_ack               RAM port accepted the current write
//   loader_en             loader owns the RAM port (CPU held off)
//   loader_wr/addr/data   write request (held until mem_ack), address, data
//   loader_jump           one-cycle request to start execution at execute_addr
//   execute_addr [15:0]   transfer address taken from the file
//   load_err              sticky truncated-file flag, cleared on next load
module cmd_loader #(
  parameter logic [7:0] CMD_INDEX = 8'd2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        mem_ack,
  output logic        loader_en,
  output logic        loader_wr,
  output logic [15:0] loader_addr,
  output logic [7:0]  loader_data,
  output logic        loader_jump,
  output logic [15:0] execute_addr,
  output logic        load_err
);

  typedef enum logic [3:0] {
    IDLE,
    GET_TYPE,
    GET_LEN,
    GET_LSB,
    GET_MSB,
    TRANSFER,
    WRITE,
    IGNORE,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    BLK_LOAD,
    BLK_XFER,
    BLK_CMNT
  } blk_t;

  state_t      state_q, state_d;
  blk_t        blk_q, blk_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] loader_addr_q, loader_addr_d;
  logic [7:0]  loader_data_q, loader_data_d;
  logic [15:0] execute_addr_q, execute_addr_d;
  logic        xfer_valid_q, xfer_valid_d;
  logic        loader_en_q, loader_en_d;
  logic        loader_wr_q, loader_wr_d;
  logic        ioctl_wait_q, ioctl_wait_d;
  logic        loader_jump_q, loader_jump_d;
  logic        load_err_q, load_err_d;
  logic        end_pend_q, end_pend_d;
  logic        dl_q;

  logic        dl_rise;
  logic        dl_fall;
  logic [7:0]  len_m2;
  state_t      post_state;

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  assign len_m2  = ioctl_dout - 8'd2;

  always_comb begin
    state_d        = state_q;
    blk_d          = blk_q;
    cnt_d          = cnt_q;
    loader_addr_d  = loader_addr_q;
    loader_data_d  = loader_data_q;
    execute_addr_d = execute_addr_q;
    xfer_valid_d   = xfer_valid_q;
    loader_en_d    = loader_en_q;
    loader_wr_d    = loader_wr_q;
    ioctl_wait_d   = ioctl_wait_q;
    loader_jump_d  = 1'b0;
    load_err_d     = load_err_q;
    end_pend_d     = end_pend_q;
    post_state     = state_q;

    // Byte / handshake processing first.
    case (state_q)
      IDLE: begin
        if (dl_rise && (ioctl_index == CMD_INDEX)) begin
          state_d      = GET_TYPE;
          load_err_d   = 1'b0;
          xfer_valid_d = 1'b0;
          loader_en_d  = 1'b1;
          end_pend_d   = 1'b0;
        end
      end

      GET_TYPE: begin
        if (ioctl_wr) begin
          case (ioctl_dout)
            8'h01:   begin blk_d = BLK_LOAD; state_d = GET_LEN; end
            8'h02:   begin blk_d = BLK_XFER; state_d = GET_LEN; end
            8'h00:   state_d = DRAIN;
            default: begin blk_d = BLK_CMNT; state_d = GET_LEN; end
          endcase
        end
      end

      GET_LEN: begin
        if (ioctl_wr) begin
          case (blk_q)
            // Length byte includes the two address bytes; 0 encodes 256.
            BLK_LOAD: begin
              cnt_d   = {len_m2 == 8'd0, len_m2};
              state_d = GET_LSB;
            end
            BLK_XFER: state_d = GET_LSB;
            default: begin
              cnt_d   = {ioctl_dout == 8'd0, ioctl_dout};
              state_d = IGNORE;
            end
          endcase
        end
      end

      GET_LSB: begin
        if (ioctl_wr) begin
          if (blk_q == BLK_XFER) execute_addr_d[7:0] = ioctl_dout;
          else                   loader_addr_d[7:0]  = ioctl_dout;
          state_d = GET_MSB;
        end
      end

      GET_MSB: begin
        if (ioctl_wr) begin
          if (blk_q == BLK_XFER) begin
            execute_addr_d[15:8] = ioctl_dout;
            xfer_valid_d         = 1'b1;
            state_d              = DRAIN;
          end else begin
            loader_addr_d[15:8] = ioctl_dout;
            state_d             = TRANSFER;
          end
        end
      end

      TRANSFER: begin
        if (ioctl_wr) begin
          loader_data_d = ioctl_dout;
          loader_wr_d   = 1'b1;
          ioctl_wait_d  = 1'b1;
          state_d       = WRITE;
        end
      end

      WRITE: begin
        if (mem_ack) begin
          loader_wr_d   = 1'b0;
          ioctl_wait_d  = 1'b0;
          loader_addr_d = loader_addr_q + 16'd1;
          cnt_d         = cnt_q - 9'd1;
          state_d       = (cnt_q == 9'd1) ? GET_TYPE : TRANSFER;
        end
      end

      IGNORE: begin
        if (ioctl_wr) begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = GET_TYPE;
        end
      end

      DRAIN: ;

      default: state_d = IDLE;
    endcase

    // End-of-download rules act on the state reached after this cycle's
    // byte; a write still in flight defers them until its mem_ack.
    if ((state_q != IDLE) && (dl_fall || end_pend_q)) begin
      post_state = state_d;
      if (post_state == WRITE) begin
        end_pend_d = 1'b1;
      end else begin
        state_d      = IDLE;
        loader_en_d  = 1'b0;
        ioctl_wait_d = 1'b0;
        end_pend_d   = 1'b0;
        if ((post_state == DRAIN) || (post_state == GET_TYPE)) begin
          loader_jump_d = xfer_valid_d;
        end else begin
          load_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      blk_q          <= BLK_LOAD;
      cnt_q          <= '0;
      loader_addr_q  <= '0;
      loader_data_q  <= '0;
      execute_addr_q <= '0;
      xfer_valid_q   <= 1'b0;
      loader_en_q    <= 1'b0;
      loader_wr_q    <= 1'b0;
      ioctl_wait_q   <= 1'b0;
      loader_jump_q  <= 1'b0;
      load_err_q     <= 1'b0;
      end_pend_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      blk_q          <= blk_d;
      cnt_q          <= cnt_d;
      loader_addr_q  <= loader_addr_d;
      loader_data_q  <= loader_data_d;
      execute_addr_q <= execute_addr_d;
      xfer_valid_q   <= xfer_valid_d;
      loader_en_q    <= loader_en_d;
      loader_wr_q    <= loader_wr_d;
      ioctl_wait_q   <= ioctl_wait_d;
      loader_jump_q  <= loader_jump_d;
      load_err_q     <= load_err_d;
      end_pend_q     <= end_pend_d;
    end
  end

  // Edge detector keeps tracking through reset so a download that is still
  // high when reset releases is not mistaken for a new start.
  always_ff @(posedge clk_sys) begin
    dl_q <= ioctl_download;
  end

  assign ioctl_wait   = ioctl_wait_q;
  assign loader_en    = loader_en_q;
  assign loader_wr    = loader_wr_q;
  assign loader_addr  = loader_addr_q;
  assign loader_data  = loader_data_q;
  assign loader_jump  = loader_jump_q;
  assign execute_addr = execute_addr_q;
  assign load_err     = load_err_q;

endmodule

// File: tb/tb_cmd_loader.sv
module tb_cmd_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_ack;
  logic        loader_en;
  logic        loader_wr;
  logic [15:0] loader_addr;
  logic [7:0]  loader_data;
  logic        loader_jump;
  logic [15:0] execute_addr;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  // RAM responder: ack tied high, or ack after loader_wr has been high ack_delay cycles
  logic        ack_tied = 1'b1;
  int unsigned ack_delay = 0;
  int unsigned wr_cyc = 0;

  // Monitors
  logic [23:0] wlog[$];
  int jump_cnt = 0;
  int viol_cnt = 0;
  int en_cnt   = 0;
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  always @(posedge clk) wr_cyc <= loader_wr ? wr_cyc + 1 : 0;
  assign mem_ack = ack_tied | (loader_wr & (wr_cyc == ack_delay));

  always @(posedge clk) begin
    if (loader_wr && mem_ack) wlog.push_back({loader_addr, loader_data});
    if (loader_jump) jump_cnt++;
    if ((loader_wr && !ioctl_wait) || (ioctl_wr && ioctl_wait)) viol_cnt++;
    if (loader_en) en_cnt++;
  end

  cmd_loader #(.CMD_INDEX(8'd2)) dut (
    .clk_sys        (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_ack        (mem_ack),
    .loader_en      (loader_en),
    .loader_wr      (loader_wr),
    .loader_addr    (loader_addr),
    .loader_data    (loader_data),
    .loader_jump    (loader_jump),
    .execute_addr   (execute_addr),
    .load_err       (load_err)
  );

  task automatic start_dl(input logic [7:0] idx);
    @(posedge clk); #1;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic end_dl();
    @(posedge clk); #1;
    ioctl_download = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_wr(input logic [7:0] b);
    @(posedge clk); #1;
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    @(posedge clk); #1;
    ioctl_wr   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    pulse_wr(b);
    n = 0;
    while (ioctl_wait && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (ioctl_wait) begin
      checks++; errors++;
      $display("FAIL wait_timeout: ioctl_wait=%b after %0d cycles, required 0", ioctl_wait, n);
    end
  endtask

  task automatic send_q();
    while (txq.size() > 0) send_byte(txq.pop_front());
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ioctl_wait !== 1'b0)      begin errors++; $display("FAIL rst_wait: got %b want 0", ioctl_wait); end
    checks++; if (loader_en !== 1'b0)       begin errors++; $display("FAIL rst_en: got %b want 0", loader_en); end
    checks++; if (loader_wr !== 1'b0)       begin errors++; $display("FAIL rst_wr: got %b want 0", loader_wr); end
    checks++; if (loader_jump !== 1'b0)     begin errors++; $display("FAIL rst_jump: got %b want 0", loader_jump); end
    checks++; if (load_err !== 1'b0)        begin errors++; $display("FAIL rst_err: got %b want 0", load_err); end
    checks++; if (loader_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h want 0000", loader_addr); end
    checks++; if (loader_data !== 8'h00)    begin errors++; $display("FAIL rst_data: got %h want 00", loader_data); end
    checks++; if (execute_addr !== 16'h0000) begin errors++; $display("FAIL rst_exec: got %h want 0000", execute_addr); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_block();
    int wb, jb;
    wb = wlog.size(); jb = jump_cnt;
    start_dl(8'd2);
    checks++; if (loader_en !== 1'b1) begin errors++; $display("FAIL load_en_rise: got %b want 1", loader_en); end
    txq = '{8'h01, 8'h05, 8'h00, 8'h52};
    send_q();
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL load_hdr_stall: got %b want 0", ioctl_wait); end
    pulse_wr(8'hAA);
    checks++; if ({loader_wr, ioctl_wait} !== 2'b11) begin errors++; $display("FAIL load_wr_rise: wr/wait got %b want 11", {loader_wr, ioctl_wait}); end
    checks++; if ({loader_addr, loader_data} !== 24'h5200AA) begin errors++; $display("FAIL load_wr_bus: got %h want 5200AA", {loader_addr, loader_data}); end
    @(posedge clk); #1;
    checks++; if ({loader_wr, ioctl_wait} !== 2'b00) begin errors++; $display("FAIL load_wr_fall: wr/wait got %b want 00", {loader_wr, ioctl_wait}); end
    txq = '{8'hBB, 8'hCC, 8'h02, 8'h02, 8'h00, 8'h52};
    send_q();
    end_dl();
    checks++; if ({loader_jump, loader_en} !== 2'b10) begin errors++; $display("FAIL load_jump_en: jump/en got %b want 10", {loader_jump, loader_en}); end
    @(posedge clk); #1;
    checks++; if (loader_jump !== 1'b0) begin errors++; $display("FAIL load_jump_pulse: got %b want 0", loader_jump); end
    checks++; if (jump_cnt - jb != 1) begin errors++; $display("FAIL load_jump_cnt: got %0d want 1", jump_cnt - jb); end
    checks++; if (execute_addr !== 16'h5200) begin errors++; $display("FAIL load_exec: got %h want 5200", execute_addr); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", load_err); end
    checks++;
    if (wlog.size() - wb != 3 || wlog[wb] !== 24'h5200AA || wlog[wb+1] !== 24'h5201BB || wlog[wb+2] !== 24'h5202CC) begin
      errors++; $display("FAIL load_writes: got %0d writes, want 3 (5200AA 5201BB 5202CC)", wlog.size() - wb);
    end
  endtask

  task automatic test_length_wrap();
    int wb, jb, bad;
    logic [7:0] d;
    wb = wlog.size(); jb = jump_cnt;
    start_dl(8'd2);
    txq = '{8'h01, 8'h02, 8'h00, 8'h60};
    for (int i = 0; i < 256; i++) begin
      d = 8'(i) ^ 8'h5A;
      txq.push_back(d);
    end
    send_q();
    checks++; if (loader_addr !== 16'h6100) begin errors++; $display("FAIL wrap_addr: got %h want 6100", loader_addr); end
    txq = '{8'h02, 8'h02, 8'h34, 8'h12};
    send_q();
    end_dl();
    @(posedge clk); #1;
    bad = 0;
    if (wlog.size() - wb != 256) bad = 1;
    else
      for (int i = 0; i < 256; i++) begin
        d = 8'(i) ^ 8'h5A;
        if (wlog[wb+i] !== {16'h6000 + 16'(i), d}) bad++;
      end
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_writes: count=%0d bad=%0d want 256 bad=0", wlog.size() - wb, bad); end
    checks++; if (execute_addr !== 16'h1234) begin errors++; $display("FAIL wrap_exec: got %h want 1234", execute_addr); end
    checks++; if (jump_cnt - jb != 1) begin errors++; $display("FAIL wrap_jump: got %0d want 1", jump_cnt - jb); end
  endtask

  task automatic test_comment_skip();
    int wb, jb;
    wb = wlog.size(); jb = jump_cnt;
    start_dl(8'd2);
    txq = '{8'h05, 8'h03, 8'h41, 8'h42, 8'h43, 8'h01, 8'h03, 8'hFF, 8'hFF, 8'h7E, 8'h00, 8'h99};
    send_q();
    checks++; if (loader_addr !== 16'h0000) begin errors++; $display("FAIL skip_addr_wrap: got %h want 0000", loader_addr); end
    end_dl();
    @(posedge clk); #1;
    checks++; if (wlog.size() - wb != 1 || wlog[wb] !== 24'hFFFF7E) begin errors++; $display("FAIL skip_writes: got %0d writes, want 1 (FFFF7E)", wlog.size() - wb); end
    checks++; if (jump_cnt - jb != 0) begin errors++; $display("FAIL skip_jump: got %0d want 0", jump_cnt - jb); end
    checks++; if ({load_err, loader_en} !== 2'b00) begin errors++; $display("FAIL skip_err_en: got %b want 00", {load_err, loader_en}); end
  endtask

  task automatic test_backpressure();
    int wb, jb, vb;
    wb = wlog.size(); jb = jump_cnt; vb = viol_cnt;
    ack_tied = 1'b0; ack_delay = 5;
    start_dl(8'd2);
    txq = '{8'h01, 8'h06, 8'h00, 8'h80, 8'h10, 8'h20, 8'h30, 8'h40, 8'h02, 8'h02, 8'h00, 8'h80};
    send_q();
    end_dl();
    @(posedge clk); #1;
    checks++; if (viol_cnt - vb != 0) begin errors++; $display("FAIL bp_wait_hold: got %0d violations want 0", viol_cnt - vb); end
    checks++;
    if (wlog.size() - wb != 4 || wlog[wb] !== 24'h800010 || wlog[wb+1] !== 24'h800120 ||
        wlog[wb+2] !== 24'h800230 || wlog[wb+3] !== 24'h800340) begin
      errors++; $display("FAIL bp_writes: got %0d writes, want 4 (800010..800340)", wlog.size() - wb);
    end
    checks++; if (jump_cnt - jb != 1 || execute_addr !== 16'h8000) begin errors++; $display("FAIL bp_jump: jumps=%0d exec=%h want 1/8000", jump_cnt - jb, execute_addr); end
    ack_tied = 1'b1; ack_delay = 0;
  endtask

  task automatic test_truncated();
    int wb, jb;
    wb = wlog.size(); jb = jump_cnt;
    start_dl(8'd2);
    txq = '{8'h01, 8'h06, 8'h00, 8'h70, 8'h11};
    send_q();
    end_dl();
    @(posedge clk); #1;
    checks++; if (wlog.size() - wb != 1 || wlog[wb] !== 24'h700011) begin errors++; $display("FAIL trunc_writes: got %0d writes want 1 (700011)", wlog.size() - wb); end
    checks++; if ({load_err, loader_en} !== 2'b10) begin errors++; $display("FAIL trunc_err_en: got %b want 10", {load_err, loader_en}); end
    checks++; if (jump_cnt - jb != 0) begin errors++; $display("FAIL trunc_jump: got %0d want 0", jump_cnt - jb); end
  endtask

  task automatic test_end_during_write();
    int wb, jb, n;
    wb = wlog.size(); jb = jump_cnt;
    ack_tied = 1'b0; ack_delay = 5;
    start_dl(8'd2);
    txq = '{8'h01, 8'h04, 8'h00, 8'h90};
    send_q();
    // data byte and download end in the same cycle
    @(posedge clk); #1;
    ioctl_dout = 8'h66; ioctl_wr = 1'b1; ioctl_download = 1'b0;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    checks++; if ({loader_en, loader_wr} !== 2'b11) begin errors++; $display("FAIL ewr_pending: en/wr got %b want 11", {loader_en, loader_wr}); end
    n = 0;
    while (loader_en && n < 30) begin @(posedge clk); #1; n++; end
    checks++; if (loader_en !== 1'b0 || n < 5) begin errors++; $display("FAIL ewr_en_fall: en=%b after %0d cycles want 0 after >=5", loader_en, n); end
    checks++; if ({loader_wr, load_err} !== 2'b01) begin errors++; $display("FAIL ewr_err: wr/err got %b want 01", {loader_wr, load_err}); end
    @(posedge clk); #1;
    checks++; if (wlog.size() - wb != 1 || wlog[wb] !== 24'h900066 || jump_cnt != jb) begin
      errors++; $display("FAIL ewr_writes: got %0d writes %0d jumps want 1 (900066) 0", wlog.size() - wb, jump_cnt - jb);
    end
    ack_tied = 1'b1; ack_delay = 0;
  endtask

  task automatic test_index_filter();
    int wb, eb;
    wb = wlog.size(); eb = en_cnt;
    start_dl(8'd1);
    txq = '{8'h01, 8'h03, 8'h00, 8'h50, 8'hAA};
    send_q();
    end_dl();
    @(posedge clk); #1;
    checks++; if (en_cnt - eb != 0 || wlog.size() != wb) begin errors++; $display("FAIL idx_filter: en cycles=%0d writes=%0d want 0/0", en_cnt - eb, wlog.size() - wb); end
  endtask

  task automatic test_reset_mid();
    int wb, jb, eb;
    wb = wlog.size(); jb = jump_cnt;
    ack_tied = 1'b0; ack_delay = 20;
    start_dl(8'd2);
    txq = '{8'h01, 8'h05, 8'h00, 8'hA0};
    send_q();
    pulse_wr(8'h77);
    checks++; if ({loader_en, loader_wr, ioctl_wait} !== 3'b111) begin errors++; $display("FAIL rmid_pre: got %b want 111", {loader_en, loader_wr, ioctl_wait}); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ioctl_wait, loader_en, loader_wr, loader_jump, load_err} !== 5'b0 ||
        loader_addr !== 16'h0 || loader_data !== 8'h0 || execute_addr !== 16'h0) begin
      errors++; $display("FAIL rmid_outs: ctl=%b addr=%h data=%h exec=%h want 0", {ioctl_wait, loader_en, loader_wr, loader_jump, load_err}, loader_addr, loader_data, execute_addr);
    end
    reset_n = 1'b1;
    eb = en_cnt;
    repeat (3) @(posedge clk);
    #1;
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (en_cnt != eb || jump_cnt != jb || wlog.size() != wb) begin
      errors++; $display("FAIL rmid_after: en cycles=%0d jumps=%0d writes=%0d want 0/0/0", en_cnt - eb, jump_cnt - jb, wlog.size() - wb);
    end
    ack_tied = 1'b1; ack_delay = 0;
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_dout     = 8'd0;
    test_reset();
    test_load_block();
    test_length_wrap();
    test_comment_skip();
    test_backpressure();
    test_truncated();
    test_end_during_write();
    test_index_filter();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
